uart_rx: RTL

//   UART receiver, the receive-side counterpart of uart_tx. Samples the async

---
 rtl/uart_rx.sv | 107 ++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised line, mid-bit sampling, start/data/stop framing.
// Emits one-cycle valid, frame-error or break pulses the cycle after the stop sample.
module uart_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_RECOVER} state_t;

  state_t                  r_state;
  logic [1:0]              r_sync;
  logic [CW-1:0]           r_cyc;
  logic [BW-1:0]           r_bitn;
  logic [PAYLOAD_BITS-1:0] r_sr;
  logic                    w_rxd_s;

  assign w_rxd_s = r_sync[1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state           <= S_IDLE;
      r_sync            <= 2'b11;
      r_cyc             <= '0;
      r_bitn            <= '0;
      r_sr              <= '0;
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
      uart_rx_data      <= '0;
    end else begin
      r_sync            <= {r_sync[0], uart_rxd};
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
      if (!uart_rx_en && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_cyc   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (uart_rx_en && !w_rxd_s) begin
              r_state <= S_START;
              r_cyc   <= '0;
            end
          end
          S_START: begin
            // A start bit that has gone high again by mid-bit is treated as a glitch.
            if (r_cyc == C_HALF) begin
              r_cyc   <= '0;
              r_bitn  <= '0;
              r_state <= w_rxd_s ? S_IDLE : S_DATA;
            end else begin
              r_cyc <= r_cyc + CW'(1);
            end
          end
          S_DATA: begin
            if (r_cyc == C_LAST) begin
              r_cyc <= '0;
              r_sr  <= {w_rxd_s, r_sr[PAYLOAD_BITS-1:1]};
              if (r_bitn == B_LAST) r_state <= S_STOP;
              else                  r_bitn  <= r_bitn + BW'(1);
            end else begin
              r_cyc <= r_cyc + CW'(1);
            end
          end
          S_STOP: begin
            if (r_cyc == C_LAST) begin
              r_cyc <= '0;
              if (w_rxd_s) begin
                uart_rx_data  <= r_sr;
                uart_rx_valid <= 1'b1;
                r_state       <= S_IDLE;
              end else begin
                uart_rx_break     <= (r_sr == '0);
                uart_rx_frame_err <= (r_sr != '0);
                r_state           <= S_RECOVER;
              end
            end else begin
              r_cyc <= r_cyc + CW'(1);
            end
          end
          S_RECOVER: begin
            // Hold off until the line returns high so a stuck-low line cannot retrigger.
            if (w_rxd_s) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
